// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bus between the CPU core (master) and the interrupt
// controller (slave). Carries request lines, mask/enable writes, the CPU
// acknowledge/return handshake and the controller's vector/status outputs.
interface int_ctrl_if;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       gie_we;
    logic       gie_wd;
    logic       ack;
    logic       reti;
    logic       int_req;
    logic [9:0] int_vec;
    logic [3:0] pending;
    logic [3:0] in_service;

    modport master (
        output irq_in, mask_we, mask_wd, gie_we, gie_wd, ack, reti,
        input  int_req, int_vec, pending, in_service
    );

    modport slave (
        input  irq_in, mask_we, mask_wd, gie_we, gie_wd, ack, reti,
        output int_req, int_vec, pending, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: four-source fixed-priority interrupt controller.
// Source 0 has the highest priority. Each request line is synchronised,
// edge detected and latched as pending; an IDLE/REQ/SERV state machine
// presents one vector to the CPU at a time and tracks in-service sources.
// Optional feature: define INT_CTRL_NESTING_EN to let a strictly
// higher-priority source preempt the source(s) currently in service.
module int_ctrl (
    input  logic      clk,
    input  logic      reset,
    int_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t     state;
    logic [3:0] irq_p0, irq_p1, irq_p2;
    logic [3:0] rise;
    logic [3:0] mask;
    logic       gie;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [1:0] sel;
    logic       int_req;
    logic [9:0] int_vec;
    logic [3:0] eligible;
    logic [3:0] lowest_is;
    logic [3:0] ack_clr;

    // Highest-priority (lowest index) set bit of a request vector.
    function automatic logic [1:0] prio(input logic [3:0] v);
        prio = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) prio = 2'(i);
        end
    endfunction

    // Fixed vector address for each source.
    function automatic logic [9:0] vector(input logic [1:0] idx);
        case (idx)
            2'd0:    vector = 10'h3FB;
            2'd1:    vector = 10'h3FE;
            2'd2:    vector = 10'h3FD;
            default: vector = 10'h3FC;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_p0 <= 4'b0;
            irq_p1 <= 4'b0;
            irq_p2 <= 4'b0;
        end else begin
            irq_p0 <= bus.irq_in;
            irq_p1 <= irq_p0;
            irq_p2 <= irq_p1;
        end
    end

    assign rise = irq_p1 & ~irq_p2;

    // Software-written mask and global enable; decisions see the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= 4'b0;
            gie  <= 1'b0;
        end else begin
            if (bus.mask_we) mask <= bus.mask_wd;
            if (bus.gie_we)  gie  <= bus.gie_wd;
        end
    end

    assign eligible  = pending & ~mask & {4{gie}};
    // Isolate the highest-priority source currently in service.
    assign lowest_is = in_service & (~in_service + 4'd1);
    assign ack_clr   = (state == REQ && bus.ack) ? onehot(sel) : 4'b0;

`ifdef INT_CTRL_NESTING_EN
    logic [3:0] preempt;
    // Eligible sources strictly above everything in service.
    assign preempt = eligible & (lowest_is - 4'd1);
`endif

    // Controller state machine with registered request/vector outputs;
    // a new edge arriving on the ack cycle keeps its pending bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 2'd0;
            int_req    <= 1'b0;
            int_vec    <= 10'h000;
            pending    <= 4'b0;
            in_service <= 4'b0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        sel     <= prio(eligible);
                        int_vec <= vector(prio(eligible));
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        in_service <= in_service | onehot(sel);
                        int_req    <= 1'b0;
                        int_vec    <= 10'h000;
                        state      <= SERV;
                    end
                end
                SERV: begin
                    if (bus.reti) begin
                        in_service <= in_service & ~lowest_is;
                        if ((in_service & ~lowest_is) == 4'b0) state <= IDLE;
                    end
`ifdef INT_CTRL_NESTING_EN
                    else if (|preempt) begin
                        sel     <= prio(preempt);
                        int_vec <= vector(prio(preempt));
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                    int_vec <= 10'h000;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req;
    assign bus.int_vec    = int_vec;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table followed by randomized traffic checked
// against a behavioural model of the interrupt controller.
module tb_int_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] irq;
        logic       mwe;
        logic [3:0] mwd;
        logic       gwe;
        logic       gwd;
        logic       ack;
        logic       reti;
        logic       req;
        logic [9:0] vec;
        logic [3:0] pend;
        logic [3:0] isv;
    } row_t;

    row_t rows[$];

    logic [9:0] vtab [4] = '{10'h3FB, 10'h3FE, 10'h3FD, 10'h3FC};

    // Behavioural model: sampled-input delay line, pending set, an
    // in-service set and a "waiting for ack on source m_sel" flag.
    logic [3:0] m_hist [3];
    logic [3:0] m_pend = 4'b0;
    logic [3:0] m_mask = 4'b0;
    logic       m_gie  = 1'b0;
    logic [3:0] m_srv  = 4'b0;
    bit         m_wait = 1'b0;
    int         m_sel  = 0;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    task automatic m_step();
        logic [3:0] rise, elig;
        bit nest;
`ifdef INT_CTRL_NESTING_EN
        nest = 1'b1;
`else
        nest = 1'b0;
`endif
        if (reset) begin
            for (int i = 0; i < 3; i++) m_hist[i] = 4'b0;
            m_pend = 4'b0; m_mask = 4'b0; m_gie = 1'b0;
            m_srv = 4'b0; m_wait = 1'b0; m_sel = 0;
            return;
        end
        // A request line counts as risen once it has been seen high two
        // samples back after being low three samples back.
        rise = m_hist[1] & ~m_hist[2];
        elig = m_pend & ~m_mask & {4{m_gie}};
        if (m_wait) begin
            if (bus.ack) begin
                m_pend[m_sel] = 1'b0;
                m_srv[m_sel]  = 1'b1;
                m_wait        = 1'b0;
            end
        end else if (m_srv != 4'b0) begin
            if (bus.reti) m_srv[lowest(m_srv)] = 1'b0;
            else if (nest && lowest(elig) < lowest(m_srv)) begin
                m_sel  = lowest(elig);
                m_wait = 1'b1;
            end
        end else if (elig != 4'b0) begin
            m_sel  = lowest(elig);
            m_wait = 1'b1;
        end
        m_pend = m_pend | rise;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = bus.irq_in;
        if (bus.mask_we) m_mask = bus.mask_wd;
        if (bus.gie_we)  m_gie  = bus.gie_wd;
    endtask

    task automatic check(input string name, input logic req, input logic [9:0] vec,
                         input logic [3:0] pend, input logic [3:0] isv);
        checks++;
        if (bus.int_req !== req || bus.int_vec !== vec ||
            bus.pending !== pend || bus.in_service !== isv) begin
            failures++;
            $display("FAIL %s: got req=%b vec=%h pend=%b isv=%b, expected req=%b vec=%h pend=%b isv=%b",
                     name, bus.int_req, bus.int_vec, bus.pending, bus.in_service,
                     req, vec, pend, isv);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] irq, input logic mwe,
                         input logic [3:0] mwd, input logic gwe, input logic gwd,
                         input logic a, input logic r);
        @(negedge clk);
        reset = rst;
        bus.irq_in = irq; bus.mask_we = mwe; bus.mask_wd = mwd;
        bus.gie_we = gwe; bus.gie_wd = gwd; bus.ack = a; bus.reti = r;
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic add(input logic rst, input logic [3:0] irq, input logic mwe,
                       input logic [3:0] mwd, input logic gwe, input logic gwd,
                       input logic a, input logic r, input logic req,
                       input logic [9:0] vec, input logic [3:0] pend, input logic [3:0] isv);
        row_t x;
        x.rst = rst; x.irq = irq; x.mwe = mwe; x.mwd = mwd; x.gwe = gwe; x.gwd = gwd;
        x.ack = a; x.reti = r; x.req = req; x.vec = vec; x.pend = pend; x.isv = isv;
        rows.push_back(x);
    endtask

    initial begin
        logic [3:0] irq_r;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'b0;
        bus.irq_in = 4'b0; bus.mask_we = 1'b0; bus.mask_wd = 4'b0;
        bus.gie_we = 1'b0; bus.gie_wd = 1'b0; bus.ack = 1'b0; bus.reti = 1'b0;

        //  rst irq     mwe mwd     gwe gwd ack reti | req vec      pend     isv
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000); // 0 reset
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0100, 4'b0000); // 4 pending
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FD, 4'b0100, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FD, 4'b0100, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b0100); // 7 ack
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000); // 9 two sources
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b1010, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FE, 4'b1010, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b1000, 4'b0010);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b1000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FC, 4'b1000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b1000); // 16 SERV src3
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b1000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b1000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b1000);
`ifdef INT_CTRL_NESTING_EN
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b1000); // 20 preempt
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b1001);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b1000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
`else
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b1000); // 20 no preempt
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0001, 4'b1000); // ack ignored
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b0000);
`endif
        add(0, 4'b0000, 1, 4'b0001, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000); // 26 mask src0
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b0000); // old mask used
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b0000); // 33 reset in REQ
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   0, 10'h000, 4'b0001, 4'b0000);
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0001, 4'b0001); // 40 set wins
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,   1, 10'h3FB, 4'b0001, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,   0, 10'h000, 4'b0000, 4'b0000); // stray ack
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,   0, 10'h000, 4'b0000, 4'b0000); // stray reti

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].rst, rows[i].irq, rows[i].mwe, rows[i].mwd,
                  rows[i].gwe, rows[i].gwd, rows[i].ack, rows[i].reti);
            check($sformatf("vec%0d", i), rows[i].req, rows[i].vec, rows[i].pend, rows[i].isv);
        end

        // Randomized traffic against the behavioural model.
        irq_r = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            logic rst_r, mwe_r, gwe_r, gwd_r, ack_r, reti_r;
            logic [3:0] mwd_r;
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq_r[b] = ~irq_r[b];
            rst_r  = ($urandom_range(299) == 0);
            mwe_r  = ($urandom_range(19) == 0);
            mwd_r  = 4'($urandom_range(15));
            gwe_r  = ($urandom_range(29) == 0);
            gwd_r  = ($urandom_range(3) != 0);
            ack_r  = m_wait ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            reti_r = (m_srv != 4'b0) ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
            drive(rst_r, irq_r, mwe_r, mwd_r, gwe_r, gwd_r, ack_r, reti_r);
            check($sformatf("rand%0d", c), m_wait, m_wait ? vtab[m_sel] : 10'h000, m_pend, m_srv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
